// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_pkg
// Purpose  : Shared defaults and encodings for the VGA framebuffer arbiter.
// Revision : 1.0
// ============================================================================
package vga_fb_pkg;

    localparam int ADDR_W_DEF     = 19;
    localparam int DATA_W_DEF     = 12;
    localparam int H_ACT_DEF      = 640;
    localparam int V_ACT_DEF      = 480;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int LOW_WM_DEF     = 3;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_fifo
// Purpose  : First-word-fall-through pixel FIFO with flush; head reads 0 when
//            empty.
// Revision : 1.0
// ============================================================================
module vga_pix_fifo
    import vga_fb_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                         clk25M,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A flush discards everything, including a word arriving the same cycle.
    assign w_push = push & ~flush;
    assign w_pop  = pop & ~flush & (r_count != '0);

    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk25M) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares a single-port framebuffer between display prefetch and a
//            host writer; the display only wins when its FIFO runs low.
// Revision : 1.0
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int H_ACT      = H_ACT_DEF,
    parameter int V_ACT      = V_ACT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int LOW_WM     = LOW_WM_DEF
) (
    input  logic              clk25M,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow,
    input  logic              underflow_clr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                  c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam longint              c_PIXELS    = longint'(H_ACT) * longint'(V_ACT);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(c_PIXELS - 1);
    localparam logic [c_CNT_W-1:0]  c_LOW_WM    = c_CNT_W'(LOW_WM);
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

    generate
        if (c_PIXELS > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
            $error("vga_fb_arbiter: H_ACT*V_ACT does not fit in ADDR_W bits");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("vga_fb_arbiter: FIFO_DEPTH must be a power of two >= 2");
        end
        if (LOW_WM < 1 || LOW_WM > FIFO_DEPTH) begin : g_bad_wm
            $error("vga_fb_arbiter: LOW_WM must lie in 1..FIFO_DEPTH");
        end
    endgenerate

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [ADDR_W-1:0]   w_fetch_addr_nxt;
    logic                r_rd_inflight;
    logic                r_underflow;
    grant_t              w_grant;
    logic [c_CNT_W-1:0]  w_level;
    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_empty;
    logic                w_uf_set;

    // The in-flight read already owns a FIFO slot, so it counts toward level.
    assign w_level = w_fifo_count + c_CNT_W'(r_rd_inflight);

    // Bus stays quiet during reset and on the flush cycle, whatever wr_req says.
    always_comb begin
        w_grant = IDLE;
        if (reset_n && !frame_start) begin
            if (r_state == FETCH && w_level < c_LOW_WM) begin
                w_grant = RD;
            end else if (wr_req) begin
                w_grant = WR;
            end else if (r_state == FETCH && w_level < c_DEPTH) begin
                w_grant = RD;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_addr_nxt = r_fetch_addr;
        if (frame_start) begin
            w_state_nxt      = FETCH;
            w_fetch_addr_nxt = '0;
        end else if (w_grant == RD) begin
            w_fetch_addr_nxt = r_fetch_addr + ADDR_W'(1);
            if (r_fetch_addr == c_LAST_ADDR) w_state_nxt = DONE;
        end
    end

    assign w_uf_set = pix_rd & ~frame_start & w_fifo_empty;

    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= DONE;
            r_fetch_addr  <= '0;
            r_rd_inflight <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_addr  <= w_fetch_addr_nxt;
            r_rd_inflight <= (w_grant == RD);
            r_underflow   <= w_uf_set | (r_underflow & ~underflow_clr);
        end
    end

    assign mem_rd    = (w_grant == RD);
    assign mem_wr    = (w_grant == WR);
    assign wr_ack    = mem_wr;
    assign mem_addr  = mem_wr ? wr_addr : (mem_rd ? r_fetch_addr : '0);
    assign mem_wdata = mem_wr ? wr_data : '0;
    assign underflow = r_underflow;

    vga_pix_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk25M    (clk25M),
        .reset_n   (reset_n),
        .flush     (frame_start),
        .push      (r_rd_inflight),
        .push_data (mem_rdata),
        .pop       (pix_rd & ~frame_start),
        .head      (pix_data),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Directed plus randomized bench for vga_fb_arbiter against a
//            queue-based reference model; uses a short frame (640x4).
// Revision : 1.0
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int H_ACT  = 640;
    localparam int V_ACT  = 4;
    localparam int NPIX   = H_ACT * V_ACT;
    localparam int DEPTH  = 8;
    localparam int LOWWM  = 3;

    logic              clk25M = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_rd = 1'b0;
    logic [DATA_W-1:0] pix_data;
    logic              underflow;
    logic              underflow_clr = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACT(H_ACT), .V_ACT(V_ACT),
        .FIFO_DEPTH(DEPTH), .LOW_WM(LOWWM)
    ) dut (
        .clk25M(clk25M), .reset_n(reset_n), .frame_start(frame_start),
        .pix_rd(pix_rd), .pix_data(pix_data), .underflow(underflow),
        .underflow_clr(underflow_clr), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #20 clk25M = ~clk25M;

    function automatic logic [DATA_W-1:0] pix(input int unsigned a);
        return DATA_W'(a * 37 + 32'h5A5);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Framebuffer: read data appears one cycle after the strobe.
    always @(posedge clk25M) mem_rdata <= mem_rd ? pix(32'(mem_addr)) : '0;

    // Reference model: pixel queue, one outstanding read, fetch pointer.
    logic [DATA_W-1:0] m_q[$];
    bit                m_inflight = 0;
    int                m_iaddr = 0;
    bit                m_fetch = 0;
    int                m_faddr = 0;
    bit                m_uf = 0;

    always @(negedge clk25M) begin
        int          level;
        int          gnt;
        bit          uf_set;
        logic [DATA_W-1:0] e_pix;
        if (!reset_n) begin
            m_q.delete();
            m_inflight = 0; m_fetch = 0; m_faddr = 0; m_uf = 0;
            chk("rst_pix_data", 32'(pix_data), 0);
            chk("rst_underflow", 32'(underflow), 0);
            chk("rst_mem_rd", 32'(mem_rd), 0);
            chk("rst_mem_wr", 32'(mem_wr), 0);
            chk("rst_wr_ack", 32'(wr_ack), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
        end else begin
            level = m_q.size() + int'(m_inflight);
            gnt = 0;
            if (!frame_start) begin
                if (m_fetch && level < LOWWM) gnt = 1;
                else if (wr_req) gnt = 2;
                else if (m_fetch && level < DEPTH) gnt = 1;
            end
            e_pix = (m_q.size() != 0) ? m_q[0] : '0;
            chk("pix_data", 32'(pix_data), 32'(e_pix));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("mem_rd", 32'(mem_rd), 32'(gnt == 1));
            chk("mem_wr", 32'(mem_wr), 32'(gnt == 2));
            chk("wr_ack", 32'(wr_ack), 32'(gnt == 2));
            if (gnt == 1) chk("rd_addr", 32'(mem_addr), 32'(m_faddr));
            if (gnt == 2) begin
                chk("wr_addr", 32'(mem_addr), 32'(wr_addr));
                chk("wr_data", 32'(mem_wdata), 32'(wr_data));
            end
            if (frame_start) begin
                m_q.delete();
                m_fetch = 1; m_faddr = 0;
                m_uf = m_uf & !underflow_clr;
            end else begin
                uf_set = pix_rd && (m_q.size() == 0);
                if (pix_rd && m_q.size() != 0) void'(m_q.pop_front());
                if (m_inflight) m_q.push_back(pix(m_iaddr));
                m_uf = uf_set | (m_uf & !underflow_clr);
            end
            m_inflight = (gnt == 1);
            if (gnt == 1) begin
                m_iaddr = m_faddr;
                m_faddr++;
                if (m_faddr == NPIX) m_fetch = 0;
            end
        end
    end

    // Snapshot of the outputs from the cycle run_cycle just completed.
    logic              s_rd, s_wr, s_ack, s_uf;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_pix;

    task automatic run_cycle(input bit fs, input bit pr, input bit ufc, input bit want_wr);
        frame_start = fs; pix_rd = pr; underflow_clr = ufc;
        if (want_wr && !wr_req) begin
            wr_req  = 1'b1;
            wr_addr = ADDR_W'($urandom);
            wr_data = DATA_W'($urandom);
        end
        @(negedge clk25M);
        s_rd = mem_rd; s_wr = mem_wr; s_ack = wr_ack; s_uf = underflow;
        s_addr = mem_addr; s_wdata = mem_wdata; s_pix = pix_data;
        @(posedge clk25M);
        #1;
        if (s_ack) wr_req = 1'b0;
        frame_start = 1'b0; pix_rd = 1'b0; underflow_clr = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        wr_req  = 1'b0;
        repeat (cycles) run_cycle(0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int reads;
        bit found;

        do_reset(3);
        chk("reset_pix_data", 32'(s_pix), 0);
        chk("reset_mem_rd", 32'(s_rd), 0);
        chk("reset_underflow", 32'(s_uf), 0);

        // Prefetch fill after frame_start
        run_cycle(1, 0, 0, 0);
        chk("fs_cycle_no_rd", 32'(s_rd), 0);
        for (int k = 0; k < 8; k++) begin
            run_cycle(0, 0, 0, 0);
            chk("fill_rd", 32'(s_rd), 1);
            chk("fill_addr", 32'(s_addr), 32'(k));
        end
        run_cycle(0, 0, 0, 0);
        chk("full_idle_rd", 32'(s_rd), 0);
        run_cycle(0, 0, 0, 0);
        chk("full_idle_rd2", 32'(s_rd), 0);
        chk("full_head", 32'(s_pix), 32'h5A5);

        // Write wins when the FIFO is full
        wr_req = 1'b1; wr_addr = 19'h100; wr_data = 12'hABC;
        run_cycle(0, 0, 0, 1);
        chk("wr_mem_wr", 32'(s_wr), 1);
        chk("wr_ack", 32'(s_ack), 1);
        chk("wr_addr", 32'(s_addr), 32'h100);
        chk("wr_wdata", 32'(s_wdata), 32'hABC);
        chk("wr_no_rd", 32'(s_rd), 0);

        // One active line with a greedy writer
        nw = 0;
        for (int k = 0; k < H_ACT; k++) begin
            run_cycle(0, 1, 0, 1);
            if (s_ack) nw++;
        end
        run_cycle(0, 0, 0, 0);
        chk("line_no_underflow", 32'(s_uf), 0);
        chk("line_writes_seen", 32'(nw > 0), 1);

        // Underflow set / clear / set-beats-clear
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 1, 0, 0);
        chk("uf_empty_pix", 32'(s_pix), 0);
        run_cycle(0, 0, 0, 0);
        chk("uf_set", 32'(s_uf), 1);
        run_cycle(0, 0, 1, 0);
        run_cycle(0, 0, 0, 0);
        chk("uf_cleared", 32'(s_uf), 0);
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 1, 1, 0);
        run_cycle(0, 0, 0, 0);
        chk("uf_set_wins", 32'(s_uf), 1);

        // frame_start right after a read drops the returning word
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            run_cycle(0, 1, 0, 0);
            found = s_rd;
        end
        chk("stale_rd_found", 32'(found), 1);
        run_cycle(1, 1, 0, 0);
        run_cycle(0, 0, 0, 0);
        chk("stale_dropped_pix", 32'(s_pix), 0);
        chk("restart_rd", 32'(s_rd), 1);
        chk("restart_addr", 32'(s_addr), 0);

        // Mid-operation reset
        do_reset(2);
        chk("midrst_rd", 32'(s_rd), 0);
        chk("midrst_pix", 32'(s_pix), 0);

        // Whole frame: stop at the last pixel, then writer owns the bus
        run_cycle(1, 0, 0, 0);
        reads = 0;
        for (int k = 0; k < 3 * NPIX && reads < NPIX; k++) begin
            run_cycle(0, 1, 0, 0);
            if (s_rd) begin
                chk("frame_addr", 32'(s_addr), 32'(reads));
                reads++;
            end
        end
        chk("frame_reads", 32'(reads), 32'(NPIX));
        for (int k = 0; k < 16; k++) begin
            run_cycle(0, 1, 0, 1);
            chk("done_wr_ack", 32'(s_ack), 1);
            chk("done_no_rd", 32'(s_rd), 0);
        end
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 0, 0, 0);
        chk("next_frame_rd", 32'(s_rd), 1);
        chk("next_frame_addr", 32'(s_addr), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 699) == 0) do_reset(2);
            run_cycle($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 8,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
